// File: rtl/ov7670_config_seq.sv
// OV7670 register-table sequencer: walks a synchronous config ROM, interprets delay/end markers and
// issues SCCB register writes over valid/ready. Define CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times.

module ov7670_config_seq #(
   parameter int unsigned       ADDR_W       = 8,
   parameter int unsigned       DATA_W       = 16,
   parameter logic [DATA_W-1:0] END_CODE     = 16'hFFFF,
   parameter logic [DATA_W-1:0] DELAY_CODE   = 16'hFFF0,
   parameter int unsigned       DELAY_CYCLES = 250000,
   parameter int unsigned       MAX_RETRY    = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clk_en_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [7:0]        cmd_reg_o,
   output logic [7:0]        cmd_data_o,
   input  logic              wr_done_i,
   input  logic              wr_nack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
`ifdef CFG_RETRY_EN
   ,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT_ACK, S_DELAY, S_ADVANCE, S_FIN, S_ERR
   } state_e;

   localparam int unsigned         CNT_W      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0]   ADDR_LAST  = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [7:0]        reg_q, reg_d;
   logic [7:0]        data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              retryOk;

   logic [7:0] romReg;
   logic [7:0] romVal;
   assign romReg = rom_data_i[DATA_W-1 -: 8];
   assign romVal = rom_data_i[7:0];

`ifdef CFG_RETRY_EN
   localparam int unsigned RTY_W = $clog2(MAX_RETRY+1);
   logic [RTY_W-1:0] retry_q, retry_d;

   assign retryOk = (retry_q < RTY_W'(MAX_RETRY));

   // Count only NACKs that lead to a resend; cleared on every new entry and on start.
   always_comb begin
      retry_d = retry_q;
      if (clk_en_i) begin
         if (state_q == S_IDLE && start_i) begin
            retry_d = '0;
         end else if (state_q == S_WAIT_ACK && wr_done_i && wr_nack_i && retryOk) begin
            retry_d = retry_q + 1'b1;
         end else if (state_d == S_ADVANCE && state_q != S_ADVANCE) begin
            retry_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end

   assign retry_cnt_o = retry_q;
`else
   assign retryOk = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clk_en_i) begin
         case (state_q)
            S_IDLE:     if (start_i) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
               if (rom_data_i == END_CODE) begin
                  state_d = S_FIN;
               end else if (rom_data_i == DELAY_CODE) begin
                  state_d = S_DELAY;
               end else begin
                  state_d = S_SEND;
               end
            end
            S_SEND:     if (valid_q && cmd_ready_i) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
               if (wr_done_i) begin
                  if (!wr_nack_i) begin
                     state_d = S_ADVANCE;
                  end else if (retryOk) begin
                     state_d = S_SEND;
                  end else begin
                     state_d = S_ERR;
                  end
               end
            end
            S_DELAY:    if (cnt_q == '0) state_d = S_ADVANCE;
            // The table never wraps: the last address finishes the run.
            S_ADVANCE:  state_d = (addr_q == ADDR_LAST) ? S_FIN : S_FETCH;
            S_FIN:      state_d = S_IDLE;
            S_ERR:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      addr_d  = addr_q;
      valid_d = valid_q;
      reg_d   = reg_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      cnt_d   = cnt_q;
      if (clk_en_i) begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  addr_d  = '0;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  error_d = 1'b0;
               end
            end
            S_DECODE: begin
               if (rom_data_i == DELAY_CODE) begin
                  cnt_d = DELAY_LOAD;
               end else if (rom_data_i != END_CODE) begin
                  reg_d   = romReg;
                  data_d  = romVal;
                  valid_d = 1'b1;
               end
            end
            S_SEND:     if (valid_q && cmd_ready_i) valid_d = 1'b0;
            S_WAIT_ACK: if (wr_done_i && wr_nack_i && retryOk) valid_d = 1'b1;
            S_DELAY:    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            S_ADVANCE:  if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
            S_FIN: begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            S_ERR: begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         valid_q <= 1'b0;
         reg_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         valid_q <= valid_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rom_addr_o  = addr_q;
   assign cmd_valid_o = valid_q;
   assign cmd_reg_o   = reg_q;
   assign cmd_data_o  = data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: directed and randomized table runs checked against a table-walking reference model.
// Covers the default build and the CFG_RETRY_EN build.

module tb_ov7670_config_seq;

   localparam int ADDR_W       = 3;
   localparam int N            = 1 << ADDR_W;
   localparam int DELAY_CYCLES = 4;
   localparam int MAX_RETRY    = 3;
   localparam logic [15:0] END_CODE   = 16'hFFFF;
   localparam logic [15:0] DELAY_CODE = 16'hFFF0;
`ifdef CFG_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              rstN;
   logic              clkEn;
   logic              start;
   logic [ADDR_W-1:0] romAddr;
   logic [15:0]       romData = '0;
   logic              cmdValid;
   logic              cmdReady;
   logic [7:0]        cmdReg;
   logic [7:0]        cmdData;
   logic              wrDone;
   logic              wrNack;
   logic              busy;
   logic              done;
   logic              error;
`ifdef CFG_RETRY_EN
   logic [$clog2(MAX_RETRY+1)-1:0] retryCnt;
`endif

   logic [15:0] rom [N];

   // Clock generation and the synchronous config ROM the sequencer reads.
   always #5 clock = ~clock;
   always @(posedge clock) romData <= rom[romAddr];

   ov7670_config_seq #(
      .ADDR_W(ADDR_W), .DATA_W(16), .END_CODE(END_CODE), .DELAY_CODE(DELAY_CODE),
      .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk_i(clock), .rst_ni(rstN), .clk_en_i(clkEn), .start_i(start),
      .rom_addr_o(romAddr), .rom_data_i(romData),
      .cmd_valid_o(cmdValid), .cmd_ready_i(cmdReady), .cmd_reg_o(cmdReg), .cmd_data_o(cmdData),
      .wr_done_i(wrDone), .wr_nack_i(wrNack),
      .busy_o(busy), .done_o(done), .error_o(error)
`ifdef CFG_RETRY_EN
      , .retry_cnt_o(retryCnt)
`endif
   );

   int errCount   = 0;
   int checkCount = 0;

   // Test knobs: enMode 0=always,1=one-of-three,2=random; readyMode 0=always,1=random,2=10-cycle stall; latMode<0 random.
   int enMode, readyMode, latMode;
   bit nackPlan[$];

   logic [15:0] expWr[$];
   int          expGap[$];
   bit          expDone, expErr;
   int          expAddr;

   // Single comparison point: every check is counted here and a mismatch prints one FAIL line.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: walks the table entry by entry and predicts every write, the enabled-cycle gap
   // before each request appears, and how the run ends.
   task automatic buildModel();
      int k = 0;
      int base = 3;
      int p = 0;
      int tries;
      bit nack;
      expWr.delete();
      expGap.delete();
      expDone = 1'b0;
      expErr  = 1'b0;
      expAddr = N - 1;
      for (int i = 0; i < N; i++) begin
         if (rom[i] == END_CODE) begin
            expDone = 1'b1;
            expAddr = i;
            return;
         end
         if (rom[i] == DELAY_CODE) begin
            k++;
            continue;
         end
         tries = 0;
         forever begin
            expWr.push_back(rom[i]);
            expGap.push_back(tries == 0 ? base + k * (DELAY_CYCLES + 3) : 1);
            nack = (p < nackPlan.size()) ? nackPlan[p] : 1'b0;
            p++;
            if (!nack) break;
            tries++;
            if (!RETRY_ON || tries > MAX_RETRY) begin
               expErr  = 1'b1;
               expAddr = i;
               return;
            end
         end
         k    = 0;
         base = 4;
      end
      expDone = 1'b1;
   endtask

   // Run one configuration pass: acts as SCCB master, records handshakes and gaps, then checks against the model.
   task automatic applyStimulus(input string name);
      logic [15:0] obsWr[$];
      int gaps[$];
      int rawGaps[$];
      int cyc = 0, enGap = 0, rawGap = 0, doneWait = -1, planIdx = 0, bpCnt = 0, stabErr = 0;
      bit started = 0, finished = 0, counting = 0;
      bit en, rdy, wd = 0, nk = 0, st = 1;
      logic pValid;
      logic [7:0] pReg, pData;
      buildModel();
      en = (enMode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = (readyMode == 0);
      clkEn = en; cmdReady = rdy; start = st; wrDone = 0; wrNack = 0;
      pValid = cmdValid; pReg = cmdReg; pData = cmdData;
      while (!finished && cyc < 4000) begin
         @(posedge clock);
         #1;
         cyc++;
         rawGap++;
         if (en) begin
            enGap++;
            if (st) begin started = 1; st = 0; enGap = 1; rawGap = 1; counting = 1; end
            if (wd) begin wd = 0; nk = 0; enGap = 1; rawGap = 1; counting = 1; end
            if (pValid && rdy) begin
               obsWr.push_back({pReg, pData});
               doneWait = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
            end else if (doneWait > 0) begin
               doneWait--;
            end
         end
         if (pValid && !(en && rdy)) begin
            if (!cmdValid || cmdReg !== pReg || cmdData !== pData) stabErr++;
         end
         if (!pValid && cmdValid) begin
            gaps.push_back(counting ? enGap : -1);
            rawGaps.push_back(counting ? rawGap : -1);
            counting = 0;
         end
         if (started && !busy && (done || error)) finished = 1;
         pValid = cmdValid; pReg = cmdReg; pData = cmdData;
         if (doneWait == 0) begin
            wd = 1;
            nk = (planIdx < nackPlan.size()) ? nackPlan[planIdx] : 1'b0;
            planIdx++;
            doneWait = -1;
         end
         case (readyMode)
            0: rdy = 1;
            1: rdy = $urandom_range(0, 1) != 0;
            default: begin
               if (cmdValid && bpCnt < 10) begin rdy = 0; bpCnt++; end
               else begin rdy = 1; if (!cmdValid) bpCnt = 0; end
            end
         endcase
         case (enMode)
            0: en = 1;
            1: en = (cyc % 3 == 0);
            default: en = ($urandom_range(0, 3) != 0);
         endcase
         clkEn = en; cmdReady = rdy; start = st; wrDone = wd; wrNack = nk;
      end
      start = 0; wrDone = 0; wrNack = 0; clkEn = 1; cmdReady = 0;
      checkOutput({name, ".finished"}, 32'(finished), 32'd1);
      checkOutput({name, ".writes"}, obsWr.size(), expWr.size());
      for (int i = 0; i < expWr.size() && i < obsWr.size(); i++)
         checkOutput($sformatf("%s.wr%0d", name, i), 32'(obsWr[i]), 32'(expWr[i]));
      checkOutput({name, ".rises"}, gaps.size(), expGap.size());
      for (int i = 0; i < expGap.size() && i < gaps.size(); i++) begin
         checkOutput($sformatf("%s.gap%0d", name, i), gaps[i], expGap[i]);
         if (enMode == 1)
            checkOutput($sformatf("%s.rawgap%0d", name, i), rawGaps[i], 3 * (expGap[i] - 1) + 1);
      end
      checkOutput({name, ".stable"}, stabErr, 0);
      checkOutput({name, ".done"}, 32'(done), 32'(expDone));
      checkOutput({name, ".error"}, 32'(error), 32'(expErr));
      checkOutput({name, ".busy"}, 32'(busy), 32'd0);
      checkOutput({name, ".addr"}, 32'(romAddr), expAddr);
`ifdef CFG_RETRY_EN
      checkOutput({name, ".retry"}, 32'(retryCnt), expErr ? MAX_RETRY : 0);
`endif
   endtask

   task automatic loadBasic();
      rom[0] = 16'h1280; rom[1] = DELAY_CODE; rom[2] = 16'h1200; rom[3] = 16'h3A14; rom[4] = END_CODE;
      for (int i = 5; i < N; i++) rom[i] = 16'h5A00 + 16'(i);
   endtask

   task automatic loadRandom(input bit allowEnd);
      logic [15:0] w;
      for (int i = 0; i < N; i++) begin
         int r = $urandom_range(0, 9);
         w = 16'($urandom);
         if (w == END_CODE || w == DELAY_CODE) w = w ^ 16'h0101;
         if (r >= 7 && r <= 8) w = DELAY_CODE;
         if (r == 9 && allowEnd) w = END_CODE;
         rom[i] = w;
      end
   endtask

   initial begin
      rstN = 0; clkEn = 0; start = 0; cmdReady = 0; wrDone = 0; wrNack = 0;
      for (int i = 0; i < N; i++) rom[i] = '0;
      #12;
      checkOutput("reset.addr", 32'(romAddr), 32'd0);
      checkOutput("reset.valid", 32'(cmdValid), 32'd0);
      checkOutput("reset.payload", 32'({cmdReg, cmdData}), 32'd0);
      checkOutput("reset.flags", 32'({busy, done, error}), 32'd0);
`ifdef CFG_RETRY_EN
      checkOutput("reset.retry", 32'(retryCnt), 32'd0);
`endif
      @(negedge clock) rstN = 1;

      enMode = 0; readyMode = 0; latMode = 1;
      loadBasic();
      nackPlan.delete();
      applyStimulus("basic");

      rom[0] = 16'h1280; rom[1] = END_CODE;
      readyMode = 2;
      applyStimulus("backpressure");

      loadBasic();
      readyMode = 0;
      nackPlan = '{1'b0, 1'b1};
      applyStimulus("nack");
      nackPlan = '{1'b0, 1'b1, 1'b1, 1'b0};
      applyStimulus("nack2ack");
      nackPlan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      applyStimulus("nack4");

      nackPlan.delete();
      enMode = 1;
      applyStimulus("clken3");

      // Asynchronous reset while a request is pending must drop cmd_valid before any clock edge.
      enMode = 0;
      clkEn = 1; cmdReady = 0; start = 1;
      for (int i = 0; i < 20 && !cmdValid; i++) begin
         @(posedge clock);
         #1 start = 0;
      end
      start = 0;
      checkOutput("midrst.reachSend", 32'(cmdValid), 32'd1);
      #2 rstN = 0;
      #1;
      checkOutput("midrst.valid", 32'(cmdValid), 32'd0);
      checkOutput("midrst.addr", 32'(romAddr), 32'd0);
      checkOutput("midrst.busy", 32'(busy), 32'd0);
      @(negedge clock) rstN = 1;
      applyStimulus("restart");

      for (int i = 0; i < N; i++) rom[i] = 16'h2000 + 16'(i * 3);
      rom[2] = DELAY_CODE;
      applyStimulus("nowrap");

      enMode = 2; readyMode = 1; latMode = -1;
      for (int t = 0; t < 20; t++) begin
         loadRandom(t % 4 != 0);
         nackPlan.delete();
         for (int j = 0; j < 40; j++) nackPlan.push_back($urandom_range(0, 6) == 0);
         applyStimulus($sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
